// File: rtl/dma_transfer_engine.sv
// Single-channel DMA engine: requests the bus with HLD/HLDA and copies
// length 32-bit words from src_addr to dst_addr, one read and one write per word.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start; zero-length requests complete here
// REQ     | HLD raised, waiting for HLDA (also re-entry after a lost grant)
// READ    | read strobe at src_ptr, word captured into hold_q
// WRITE   | write strobe at dst_ptr, pointers advance, counter decrements
// RELEASE | HLD dropped, waiting for HLDA to fall before pulsing done
module dma_transfer_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] src_addr,
    input  logic [15:0] dst_addr,
    input  logic [7:0]  length,
    output logic        HLD,
    input  logic        HLDA,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        bus_read,
    output logic        bus_write,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        READ    = 3'd2,
        WRITE   = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic [15:0] src_ptr, dst_ptr;
    logic [7:0]  count;
    logic [31:0] hold_q;
    logic        done_q, done_nx;
    logic        load, capture, advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            src_ptr <= 16'd0;
            dst_ptr <= 16'd0;
            count   <= 8'd0;
            hold_q  <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= done_nx;
            if (load) begin
                src_ptr <= src_addr;
                dst_ptr <= dst_addr;
                count   <= length;
            end
            if (capture) begin
                hold_q <= bus_rdata;
            end
            // 16-bit pointers wrap naturally past 0xFFFC
            if (advance) begin
                src_ptr <= src_ptr + 16'd4;
                dst_ptr <= dst_ptr + 16'd4;
                count   <= count - 8'd1;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        done_nx   = 1'b0;
        load      = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        HLD       = 1'b0;
        bus_read  = 1'b0;
        bus_write = 1'b0;
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length != 8'd0) begin
                        load     = 1'b1;
                        state_nx = REQ;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            REQ: begin
                HLD = 1'b1;
                if (HLDA) begin
                    state_nx = READ;
                end
            end
            // A lost grant leaves all state untouched; the word restarts at READ.
            READ: begin
                HLD = 1'b1;
                if (HLDA) begin
                    bus_read = 1'b1;
                    bus_addr = {16'd0, src_ptr};
                    capture  = 1'b1;
                    state_nx = WRITE;
                end else begin
                    state_nx = REQ;
                end
            end
            WRITE: begin
                HLD = 1'b1;
                if (HLDA) begin
                    bus_write = 1'b1;
                    bus_addr  = {16'd0, dst_ptr};
                    bus_wdata = hold_q;
                    advance   = 1'b1;
                    state_nx  = (count == 8'd1) ? RELEASE : READ;
                end else begin
                    state_nx = REQ;
                end
            end
            RELEASE: begin
                if (!HLDA) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = done_q;

endmodule

// File: doc/dma_transfer_engine.md
DMA_TRANSFER_ENGINE -- requirements
Module: dma_transfer_engine

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-005 src_addr  input  16  source byte address, supplied by the CPU-side DMA address register.
REQ-006 dst_addr  input  16  destination byte address.
REQ-007 length  input  8  number of 32-bit words to move.
REQ-008 HLD  output  1  bus hold request to the CPU.
REQ-009 HLDA  input  1  hold acknowledge from the CPU; the engine owns the data bus only while HLDA=1.
REQ-010 bus_addr  output  32  byte address driven to memory/IO.
REQ-011 bus_wdata  output  32  write data.
REQ-012 bus_rdata  input  32  read data, combinational from the addressed device.
REQ-013 bus_read  output  1  read strobe.
REQ-014 bus_write  output  1  write strobe.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, REQ, READ, WRITE, RELEASE.
REQ-018 IDLE with start=1 and length!=0: latch src_addr, dst_addr and length into internal pointers and counter; go to REQ.
REQ-019 IDLE with start=1 and length=0: pulse done in the next cycle; do not assert HLD; stay in IDLE.
REQ-020 start in any state other than IDLE SHALL be ignored; latched parameters SHALL remain unchanged.
REQ-021 REQ: HLD=1; go to READ on the first cycle in which HLDA=1.
REQ-022 HLD SHALL remain 1 in REQ, READ and WRITE.
REQ-023 READ: bus_read=1, bus_addr={16'b0, src_ptr}; capture bus_rdata into a 32-bit holding register at the clock edge; go to WRITE.
REQ-024 WRITE: bus_write=1, bus_addr={16'b0, dst_ptr}, bus_wdata=holding register; at the clock edge, increment src_ptr and dst_ptr by 4 and decrement the counter.
REQ-025 After WRITE, go to RELEASE if the counter was 1 before the decrement; otherwise go to READ.
REQ-026 Pointer increments SHALL wrap modulo 2^16 (0xFFFC+4 -> 0x0000).
REQ-027 Steady-state throughput SHALL be 2 cycles per word after grant.
REQ-028 If HLDA=0 in a READ or WRITE cycle, that cycle SHALL drive no strobes; pointers, counter and holding register SHALL be unchanged; the next state SHALL be REQ; the interrupted word SHALL restart from READ.
REQ-029 RELEASE: HLD=0, strobes low; wait for HLDA=0, then pulse done for one cycle and go to IDLE.
REQ-030 bus_read and bus_write SHALL never be high in the same cycle.
REQ-031 In IDLE, REQ and RELEASE, bus_read=0 and bus_write=0; bus_addr and bus_wdata SHALL be 0.

Reset
REQ-032 Asserting rst SHALL immediately force IDLE, HLD=0, bus_read=0, bus_write=0, busy=0, done=0, bus_addr=0, bus_wdata=0, and clear the pointers, counter and holding register, including mid-transfer.
REQ-033 After rst is released, the first start SHALL be honoured only on a rising clock edge.

Verification
REQ-034 start, src=0x0010, dst=0x0100, length=3, HLDA returned 2 cycles after HLD -> reads at 0x10/0x14/0x18, writes at 0x100/0x104/0x108 with matching data; 6 strobe cycles; HLD drops; done pulses once after HLDA falls.
REQ-035 start with length=0 -> done pulses the next cycle; HLD never asserted; busy stays 0.
REQ-036 src=0xFFFC, length=2 -> second read at 0x0000.
REQ-037 HLDA deasserted during the WRITE of word 2 of 4 -> no write occurs that cycle; back to REQ; on re-grant word 2 is re-read from the same address; all 4 destination words are correct; exactly 4 successful writes.
REQ-038 rst asserted during READ of word 1 of 5 -> all outputs 0 without waiting for a clock edge; a later start with length=1 completes normally.
REQ-039 start pulsed again while busy with different addresses -> ignored; the original transfer completes unaltered.
